// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the LEGv8 datapath (FETCH, DECODE, EXEC, MEM, WB).
// Holds IR and NZVC flags, handshakes with both memories and faults on bad opcodes or timeouts.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  input  logic        alu_cout,
  output logic [31:0] ir,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        uncond_br,
  output logic        reg2loc,
  output logic [1:0]  alu_src,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic        reg2write,
  output logic [1:0]  mem_to_reg,
  output logic [3:0]  flags,
  output logic        instr_done,
  output logic        fault
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ir_q, ir_d;
  logic [3:0]       flags_q, flags_d;
  logic             flag_we;

  logic is_b, is_bl, is_bcond, is_cbz, is_addi, is_adds, is_subs;
  logic is_ldur, is_stur, is_br, is_legal, bcond_taken;
  logic             dec_reg2loc;
  logic [1:0]       dec_alu_src;
  logic [2:0]       dec_alu_op;

  always_comb begin
    is_b     = (ir_q[31:26] == 6'b000101);
    is_bl    = (ir_q[31:26] == 6'b100101);
    is_bcond = (ir_q[31:24] == 8'b01010100);
    is_cbz   = (ir_q[31:24] == 8'b10110100);
    is_addi  = (ir_q[31:22] == 10'b1001000100);
    is_adds  = (ir_q[31:21] == 11'b10101011000);
    is_subs  = (ir_q[31:21] == 11'b11101011000);
    is_ldur  = (ir_q[31:21] == 11'b11111000010);
    is_stur  = (ir_q[31:21] == 11'b11111000000);
    is_br    = (ir_q[31:21] == 11'b11010110000);
    is_legal = is_b | is_bl | is_bcond | is_cbz | is_addi | is_adds |
               is_subs | is_ldur | is_stur | is_br;
    // Only B.LT is implemented; every other condition code falls through.
    bcond_taken = (ir_q[4:0] == 5'b01011) && (flags_q[3] != flags_q[1]);
    dec_reg2loc = is_adds | is_subs;
    dec_alu_src = is_addi ? 2'b01 : ((is_ldur | is_stur) ? 2'b10 : 2'b00);
    dec_alu_op  = (is_addi | is_adds | is_ldur | is_stur) ? 3'b010 :
                  (is_subs ? 3'b011 : 3'b000);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        if (flag_we) begin
          flags_d = {alu_negative, alu_zero, alu_overflow, alu_cout};
        end
        cnt_d = '0;
        if (is_addi || is_adds || is_subs) begin
          state_d = S_WB;
        end else if (is_ldur || is_stur) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          cnt_d   = '0;
          state_d = is_ldur ? S_WB : S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        cnt_d   = '0;
        state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Outputs are forced low while reset is high so a request in flight drops at once.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 2'b00;
    uncond_br  = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 2'b00;
    alu_op     = 3'b000;
    reg_write  = 1'b0;
    reg2write  = 1'b0;
    mem_to_reg = 2'b00;
    flag_we    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: imem_req = 1'b1;
        S_EXEC: begin
          reg2loc = dec_reg2loc;
          alu_src = dec_alu_src;
          alu_op  = dec_alu_op;
          flag_we = is_adds | is_subs;
          if (is_b || is_bl) begin
            pc_write  = 1'b1;
            pc_sel    = 2'b01;
            uncond_br = 1'b1;
          end
          if (is_bl) begin
            reg_write  = 1'b1;
            reg2write  = 1'b1;
            mem_to_reg = 2'b10;
          end
          if (is_br) begin
            pc_write = 1'b1;
            pc_sel   = 2'b10;
          end
          if (is_cbz) begin
            pc_write = 1'b1;
            pc_sel   = alu_zero ? 2'b01 : 2'b00;
          end
          if (is_bcond) begin
            pc_write = 1'b1;
            pc_sel   = bcond_taken ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_stur;
          alu_src  = dec_alu_src;
          alu_op   = dec_alu_op;
          pc_write = is_stur & dmem_ack;
        end
        S_WB: begin
          // ALU controls stay up so the writeback sees a stable ALU result.
          reg2loc    = dec_reg2loc;
          alu_src    = dec_alu_src;
          alu_op     = dec_alu_op;
          reg_write  = 1'b1;
          mem_to_reg = is_ldur ? 2'b01 : 2'b00;
          pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
    instr_done = pc_write;
    fault      = (state_q == S_FAULT) && !reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  assign ir    = ir_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: an instruction-level model expands each directed
// instruction into per-cycle inputs and expected outputs, compared every cycle.
module tb_multicycle_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        imem_ack, dmem_ack;
  logic        alu_zero, alu_negative, alu_overflow, alu_cout;
  logic [31:0] ir;
  logic        imem_req, dmem_req, dmem_we, pc_write, uncond_br, reg2loc;
  logic [1:0]  pc_sel, alu_src, mem_to_reg;
  logic [2:0]  alu_op;
  logic        reg_write, reg2write, instr_done, fault;
  logic [3:0]  flags;

  multicycle_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .alu_cout(alu_cout), .ir(ir), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .pc_write(pc_write), .pc_sel(pc_sel), .uncond_br(uncond_br),
    .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
    .reg2write(reg2write), .mem_to_reg(mem_to_reg), .flags(flags),
    .instr_done(instr_done), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ir;
    logic        fault, instr_done, imem_req, dmem_req, dmem_we, pc_write;
    logic [1:0]  pc_sel;
    logic        uncond_br, reg_write, reg2write;
    logic [1:0]  mem_to_reg;
    logic [3:0]  flags;
    logic        reg2loc;
    logic [1:0]  alu_src;
    logic [2:0]  alu_op;
  } out_t;

  typedef struct {
    logic        imem_ack, dmem_ack;
    logic [31:0] instr;
    logic [3:0]  nzvc;
    out_t        exp;
    out_t        care;
  } cyc_t;

  typedef enum {C_B, C_BL, C_BCOND, C_CBZ, C_ADDI, C_ADDS, C_SUBS,
                C_LDUR, C_STUR, C_BR, C_ILL} cls_t;

  cyc_t        q[$];
  string       qn[$];
  int          nCompared = 0;
  int          nMismatched = 0;
  logic [31:0] m_ir;
  logic [3:0]  m_flags;

  function automatic cls_t classify(input logic [31:0] x);
    logic [10:0] op;
    op = x[31:21];
    casez (op)
      11'b000101?????: return C_B;
      11'b100101?????: return C_BL;
      11'b01010100???: return C_BCOND;
      11'b10110100???: return C_CBZ;
      11'b1001000100?: return C_ADDI;
      11'b10101011000: return C_ADDS;
      11'b11101011000: return C_SUBS;
      11'b11111000010: return C_LDUR;
      11'b11111000000: return C_STUR;
      11'b11010110000: return C_BR;
      default:         return C_ILL;
    endcase
  endfunction

  function automatic cyc_t base_cyc();
    cyc_t c;
    c.imem_ack = 1'b0;
    c.dmem_ack = 1'b0;
    c.instr = '0;
    c.nzvc = '0;
    c.exp = '0;
    c.exp.ir = m_ir;
    c.exp.flags = m_flags;
    c.care = '1;
    c.care.reg2loc = 1'b0;
    c.care.alu_src = '0;
    c.care.alu_op = '0;
    return c;
  endfunction

  function automatic out_t sample_dut();
    out_t o;
    o.ir = ir; o.fault = fault; o.instr_done = instr_done; o.imem_req = imem_req;
    o.dmem_req = dmem_req; o.dmem_we = dmem_we; o.pc_write = pc_write; o.pc_sel = pc_sel;
    o.uncond_br = uncond_br; o.reg_write = reg_write; o.reg2write = reg2write;
    o.mem_to_reg = mem_to_reg; o.flags = flags; o.reg2loc = reg2loc;
    o.alu_src = alu_src; o.alu_op = alu_op;
    return o;
  endfunction

  task automatic push(input cyc_t c, input string nm);
    q.push_back(c);
    qn.push_back(nm);
  endtask

  task automatic add_fault(input int n, input string tag);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = base_cyc();
      c.imem_ack = 1'b1;
      c.dmem_ack = 1'b1;
      c.instr = 32'h9100_0421;
      c.exp.fault = 1'b1;
      push(c, {tag, "/fault"});
    end
  endtask

  // Expands one instruction into its expected cycle-by-cycle trace.
  task automatic add_instr(input logic [31:0] ins, input int iw, input int dw,
                           input logic [3:0] nzvc, input string tag);
    cyc_t c;
    cls_t k;
    logic taken;
    k = classify(ins);
    for (int w = 0; w <= iw && w < TO; w++) begin
      c = base_cyc();
      c.instr = ins;
      c.imem_ack = (w == iw);
      c.dmem_ack = 1'b1;
      c.exp.imem_req = 1'b1;
      push(c, {tag, "/fetch"});
    end
    if (iw >= TO) begin
      add_fault(3, tag);
      return;
    end
    m_ir = ins;
    c = base_cyc();
    c.imem_ack = 1'b1;
    c.dmem_ack = 1'b1;
    c.instr = 32'hFFFF_FFFF;
    push(c, {tag, "/decode"});
    if (k == C_ILL) begin
      add_fault(3, tag);
      return;
    end
    c = base_cyc();
    c.nzvc = nzvc;
    case (k)
      C_ADDI: begin
        c.care.alu_src = '1; c.care.alu_op = '1;
        c.exp.alu_src = 2'b01; c.exp.alu_op = 3'b010;
      end
      C_ADDS, C_SUBS: begin
        c.care.reg2loc = 1'b1; c.care.alu_src = '1; c.care.alu_op = '1;
        c.exp.reg2loc = 1'b1; c.exp.alu_src = 2'b00;
        c.exp.alu_op = (k == C_ADDS) ? 3'b010 : 3'b011;
      end
      C_LDUR, C_STUR: begin
        c.care.alu_src = '1; c.care.alu_op = '1;
        c.exp.alu_src = 2'b10; c.exp.alu_op = 3'b010;
      end
      C_B, C_BL: begin
        c.exp.pc_write = 1'b1; c.exp.instr_done = 1'b1;
        c.exp.pc_sel = 2'b01; c.exp.uncond_br = 1'b1;
        if (k == C_BL) begin
          c.exp.reg_write = 1'b1; c.exp.reg2write = 1'b1; c.exp.mem_to_reg = 2'b10;
        end
      end
      C_BR: begin
        c.care.reg2loc = 1'b1;
        c.exp.pc_write = 1'b1; c.exp.instr_done = 1'b1; c.exp.pc_sel = 2'b10;
      end
      C_CBZ: begin
        c.care.reg2loc = 1'b1; c.care.alu_op = '1;
        c.exp.pc_write = 1'b1; c.exp.instr_done = 1'b1;
        c.exp.pc_sel = nzvc[2] ? 2'b01 : 2'b00;
      end
      default: begin
        taken = (ins[4:0] == 5'b01011) && (m_flags[3] != m_flags[1]);
        c.exp.pc_write = 1'b1; c.exp.instr_done = 1'b1;
        c.exp.pc_sel = taken ? 2'b01 : 2'b00;
      end
    endcase
    push(c, {tag, "/exec"});
    if (k == C_ADDS || k == C_SUBS) m_flags = nzvc;
    if (k != C_ADDI && k != C_ADDS && k != C_SUBS && k != C_LDUR && k != C_STUR) return;
    if (k == C_LDUR || k == C_STUR) begin
      for (int w = 0; w <= dw && w < TO; w++) begin
        c = base_cyc();
        c.dmem_ack = (w == dw);
        c.imem_ack = 1'b1;
        c.instr = 32'hDEAD_BEEF;
        c.care.alu_src = '1; c.care.alu_op = '1;
        c.exp.alu_src = 2'b10; c.exp.alu_op = 3'b010;
        c.exp.dmem_req = 1'b1;
        c.exp.dmem_we = (k == C_STUR);
        if (k == C_STUR && w == dw) begin
          c.exp.pc_write = 1'b1; c.exp.instr_done = 1'b1;
        end
        push(c, {tag, "/mem"});
      end
      if (dw >= TO) begin
        add_fault(3, tag);
        return;
      end
      if (k == C_STUR) return;
    end
    c = base_cyc();
    c.exp.reg_write = 1'b1;
    c.exp.pc_write = 1'b1;
    c.exp.instr_done = 1'b1;
    c.exp.mem_to_reg = (k == C_LDUR) ? 2'b01 : 2'b00;
    push(c, {tag, "/wb"});
  endtask

  task automatic checkOutput(input string nm, input out_t e, input out_t care);
    out_t o;
    o = sample_dut();
    nCompared++;
    if (((o ^ e) & care) != '0) begin
      nMismatched++;
      $display("[TB] FAIL %s got=%h expected=%h care=%h", nm, o, e, care);
    end
  endtask

  task automatic checkValue(input string nm, input int got, input int expv);
    nCompared++;
    if (got != expv) begin
      nMismatched++;
      $display("[TB] FAIL %s got=%0d expected=%0d", nm, got, expv);
    end
  endtask

  // Plays the queued trace; entered and left on a falling edge.
  task automatic applyStimulus(input int limit, output int ncyc, output int done_at,
                               output int last_sel);
    cyc_t c;
    string nm;
    ncyc = 0;
    done_at = -1;
    last_sel = -1;
    while (q.size() > 0 && ncyc < limit) begin
      c = q.pop_front();
      nm = qn.pop_front();
      imem_ack = c.imem_ack;
      dmem_ack = c.dmem_ack;
      instr = c.instr;
      {alu_negative, alu_zero, alu_overflow, alu_cout} = c.nzvc;
      #1;
      checkOutput(nm, c.exp, c.care);
      if (instr_done) begin
        if (done_at < 0) done_at = ncyc;
        last_sel = int'(pc_sel);
      end
      ncyc++;
      @(negedge clk);
    end
    q.delete();
    qn.delete();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    {alu_negative, alu_zero, alu_overflow, alu_cout} = 4'b0000;
  endtask

  task automatic do_reset(input string nm);
    out_t z;
    z = '0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #2 reset = 1'b1;
    #1 checkOutput(nm, z, '1);
    @(negedge clk);
    reset = 1'b0;
    m_ir = '0;
    m_flags = '0;
  endtask

  initial begin
    int n, d, s;
    out_t z;
    z = '0;
    m_ir = '0;
    m_flags = '0;
    reset = 1'b0;
    instr = '0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    {alu_negative, alu_zero, alu_overflow, alu_cout} = 4'b0000;
    #1 reset = 1'b1;
    #1 checkOutput("reset_init", z, '1);
    @(negedge clk);
    reset = 1'b0;

    add_instr(32'h9100_0421, 0, 0, 4'b0000, "addi");
    checkValue("addi_len", q.size(), 4);
    applyStimulus(1000, n, d, s);
    checkValue("addi_done_cycle", d, 3);
    checkValue("addi_done_sel", s, 0);

    add_instr(32'hEB02_0020, 0, 0, 4'b1000, "subs_nv");
    add_instr(32'h5400_000B, 0, 0, 4'b0000, "blt_taken");
    checkValue("subs_blt_len", q.size(), 7);
    applyStimulus(1000, n, d, s);
    checkValue("subs_flags", int'(flags), 8);
    checkValue("blt_taken_sel", s, 1);

    add_instr(32'hEB02_0020, 0, 0, 4'b1010, "subs_nv_eq");
    add_instr(32'h5400_000B, 0, 0, 4'b0000, "blt_not");
    applyStimulus(1000, n, d, s);
    checkValue("subs_flags2", int'(flags), 10);
    checkValue("blt_not_sel", s, 0);

    add_instr(32'hAB02_0020, 0, 0, 4'b1001, "adds");
    add_instr(32'h5400_0000, 0, 0, 4'b0000, "beq_never");
    applyStimulus(1000, n, d, s);
    checkValue("beq_sel", s, 0);

    add_instr(32'hF840_0020, 0, 3, 4'b0000, "ldur_w3");
    checkValue("ldur_len", q.size(), 8);
    applyStimulus(1000, n, d, s);
    checkValue("ldur_done_cycle", d, 7);

    add_instr(32'hF800_0020, 0, 1, 4'b0000, "stur_w1");
    add_instr(32'h9400_0010, 0, 0, 4'b0000, "bl");
    add_instr(32'h1400_0004, 1, 0, 4'b0000, "b_w1");
    add_instr(32'hD61F_0000, 0, 0, 4'b0000, "br");
    add_instr(32'hB400_0040, 0, 0, 4'b0100, "cbz_taken");
    add_instr(32'hB400_0040, 0, 0, 4'b0000, "cbz_not");
    add_instr(32'h9100_0421, 2, 0, 4'b0000, "addi_w2");
    applyStimulus(1000, n, d, s);
    checkValue("mix_len", n, 5 + 3 + 4 + 3 + 3 + 3 + 6);
    checkValue("stur_done_cycle", d, 4);

    add_instr(32'h9400_0010, 0, 0, 4'b0000, "bl_alone");
    applyStimulus(1000, n, d, s);
    checkValue("bl_done_cycle", d, 2);
    checkValue("bl_sel", s, 1);

    add_instr(32'h9100_0421, TO, 0, 4'b0000, "imem_timeout");
    checkValue("timeout_len", q.size(), TO + 3);
    applyStimulus(1000, n, d, s);
    checkValue("timeout_fault", int'(fault), 1);
    checkValue("timeout_no_done", d, -1);
    do_reset("timeout_reset");
    #1 checkValue("fault_cleared", int'(fault), 0);
    checkValue("fetch_after_fault", int'(imem_req), 1);
    @(negedge clk);
    do_reset("resync_reset");

    add_instr(32'h0000_0000, 0, 0, 4'b0000, "illegal");
    checkValue("illegal_len", q.size(), 5);
    applyStimulus(1000, n, d, s);
    checkValue("illegal_no_done", d, -1);
    checkValue("illegal_fault", int'(fault), 1);
    do_reset("illegal_reset");

    add_instr(32'hF840_0020, 0, TO, 4'b0000, "dmem_timeout");
    applyStimulus(1000, n, d, s);
    checkValue("dmem_timeout_fault", int'(fault), 1);
    do_reset("dmem_timeout_reset");

    add_instr(32'hEB02_0020, 0, 0, 4'b1000, "pre_subs");
    add_instr(32'hF840_0020, 0, 2, 4'b0000, "ldur_cut");
    applyStimulus(8, n, d, s);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1 checkValue("midmem_req", int'(dmem_req), 1);
    do_reset("midmem_reset");
    add_instr(32'h9100_0421, 0, 0, 4'b0000, "addi_after");
    applyStimulus(1000, n, d, s);
    checkValue("post_reset_flags", int'(flags), 0);
    checkValue("post_reset_done", d, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
